// File: rtl/mem_read_pipe_if.sv
// Read/write port between the cache controller (master) and the
// read-pipelined backing memory (slave).
//
// Read handshake: a read request transfers on a rising edge where
// memory_read_addr_valid and memory_read_ready are both 1.
// memory_read_ready is registered state only, so the master can look at it
// before deciding what to drive. A request with memory_read_ready=0 is
// dropped, not held. Read data comes back later as a one-cycle
// memory_read_valid pulse with no backpressure. Writes (memory_write_en) are
// always taken and share memory_addr with read requests.
interface mem_read_pipe_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] memory_addr;
  logic                  memory_read_addr_valid;
  logic                  memory_read_ready;
  logic                  memory_write_en;
  logic [WORD_WIDTH-1:0] memory_write_data;
  logic [WORD_WIDTH-1:0] memory_read_data;
  logic                  memory_read_valid;

  modport master (
    output memory_addr, memory_read_addr_valid, memory_write_en, memory_write_data,
    input  memory_read_ready, memory_read_data, memory_read_valid
  );

  modport slave (
    input  memory_addr, memory_read_addr_valid, memory_write_en, memory_write_data,
    output memory_read_ready, memory_read_data, memory_read_valid
  );
endinterface

// File: rtl/mem_read_pipe.sv
// Single-port backing memory with a read-request FIFO and a fixed-depth read
// pipeline. Writes own the array port in their cycle and stall FIFO pops.
// Read data leaves stage READ_LATENCY in acceptance order.
module mem_read_pipe #(
  parameter int ADDR_WIDTH   = 32,
  parameter int WORD_WIDTH   = 32,
  parameter int MEM_AW       = 14,
  parameter int READ_LATENCY = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_read_pipe_if.slave    bus,
  output logic              busy,
  output logic              overflow_err
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_WIDTH-1:0] mem_q [2**MEM_AW];
  logic [MEM_AW-1:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [READ_LATENCY:1] vld_q, vld_d;
  logic [WORD_WIDTH-1:0] dat_q [1:READ_LATENCY];
  logic                  ovf_q, ovf_d;
  logic                  ready;
  logic                  push;
  logic                  pop;
  logic [MEM_AW-1:0]     idx;

  // Only the low MEM_AW address bits select a word.
  assign idx = bus.memory_addr[MEM_AW-1:0];

  if (ADDR_WIDTH > MEM_AW) begin : g_upper_addr
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.memory_addr[ADDR_WIDTH-1:MEM_AW];
  end

  assign ready = (count_q < CW'(FIFO_DEPTH));
  assign push  = bus.memory_read_addr_valid && ready;
  // A write cycle takes the single array port, so the head waits.
  assign pop   = !bus.memory_write_en && (count_q != '0);

  // Next-state for FIFO bookkeeping, stage valids and the sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (bus.memory_read_addr_valid && !ready);
    vld_d    = {vld_q[READ_LATENCY-1:1], pop};
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset throws away every queued and in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
    end
  end

  // Request address storage; contents are don't-care until counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= idx;
    end
  end

  // Array write port; contents survive reset and reset-cycle writes are dropped.
  always_ff @(posedge clk) begin
    if (!rst && bus.memory_write_en) begin
      mem_q[idx] <= bus.memory_write_data;
    end
  end

  // Array read into stage 1, then a plain shift through the later stages.
  always_ff @(posedge clk) begin
    if (pop) begin
      dat_q[1] <= mem_q[fifo_q[rd_ptr_q]];
    end
    for (int i = 2; i <= READ_LATENCY; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  assign bus.memory_read_ready = ready;
  assign bus.memory_read_valid = vld_q[READ_LATENCY];
  assign bus.memory_read_data  = dat_q[READ_LATENCY];
  assign busy                  = (count_q != '0) || (|vld_q);
  assign overflow_err          = ovf_q;
endmodule
